// File: rtl/gpo_event_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gpo_sched_pkg
// Brief   : Shared types, widths and field slices for the GPO event scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package gpo_sched_pkg;

    localparam int TS_WIDTH      = 64;
    localparam int GPO_CMD_WIDTH = 128;
    localparam int TS_MSB        = 127;
    localparam int TS_LSB        = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2,
        ST_FIRE  = 2'd3
    } state_e;

    function automatic logic [TS_WIDTH-1:0] cmd_ts(input logic [GPO_CMD_WIDTH-1:0] cmd);
        return cmd[TS_MSB:TS_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpo_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : gpo_event_scheduler_if
// Brief   : Command-write, timeline and GPO-core signals of the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface gpo_event_scheduler_if #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int TS_WIDTH        = 64
);
    logic                                     enable;
    logic                                     flush;
    logic                                     wr_valid;
    logic [gpo_sched_pkg::GPO_CMD_WIDTH-1:0]  wr_data;
    logic                                     wr_ready;
    logic [TS_WIDTH-1:0]                      timeline;
    logic                                     busy;
    logic                                     counter_matched;
    logic [gpo_sched_pkg::GPO_CMD_WIDTH-1:0]  gpo_data;
    logic [FIFO_DEPTH_LOG2:0]                 fifo_count;
    logic                                     overflow_error;
    logic                                     late_error;
    logic                                     err_clear;

    modport master (
        output enable, flush, wr_valid, wr_data, timeline, busy, err_clear,
        input  wr_ready, counter_matched, gpo_data, fifo_count,
               overflow_error, late_error
    );

    modport slave (
        input  enable, flush, wr_valid, wr_data, timeline, busy, err_clear,
        output wr_ready, counter_matched, gpo_data, fifo_count,
               overflow_error, late_error
    );

endinterface
`default_nettype wire

// File: rtl/gpo_event_scheduler_fifo.sv
`default_nettype none
// ============================================================================
// Module  : gpo_sched_fifo
// Brief   : Single-clock command FIFO with registered (non-fallthrough) read.
// Revision: 1.0 - initial release
// ============================================================================
module gpo_sched_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);
    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic [DEPTH_LOG2:0]   count_d;
    logic [WIDTH-1:0]      rd_data_q;

    assign full_o    = (count_q == FULL_COUNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = rd_data_q;

    always_comb begin
        count_d = count_q;
        case ({wr_en_i, rd_en_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // A push and pop on a full FIFO share one slot index; the read sees the old word.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en_i) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpo_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : gpo_event_scheduler
// Brief   : Buffers timestamped GPO commands and pulses counter_matched into
//           the GPO core when the timeline reaches the head entry.
// Revision: 1.0 - initial release
// ============================================================================
module gpo_event_scheduler #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int TS_WIDTH        = 64
) (
    input  logic                  CLK100MHZ,
    input  logic                  resetn,
    gpo_event_scheduler_if.slave  bus
);
    import gpo_sched_pkg::*;

    state_e                     state_q;
    state_e                     state_d;
    logic [GPO_CMD_WIDTH-1:0]   stage_w;
    logic [TS_WIDTH-1:0]        stage_ts_w;
    logic                       fifo_full_w;
    logic                       fifo_empty_w;
    logic [FIFO_DEPTH_LOG2:0]   fifo_count_w;
    logic                       pop_w;
    logic                       push_w;
    logic                       fire_w;
    logic                       late_set_w;
    logic                       ovf_set_w;
    logic                       avail_q;
    logic                       matched_q;
    logic [GPO_CMD_WIDTH-1:0]   gpo_data_q;
    logic                       ovf_q;
    logic                       late_q;

    // The FIFO read register doubles as the staging register.
    gpo_sched_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (GPO_CMD_WIDTH)
    ) u_fifo (
        .clk_i      (CLK100MHZ),
        .rst_ni     (resetn),
        .flush_i    (bus.flush),
        .wr_en_i    (push_w),
        .wr_data_i  (bus.wr_data),
        .rd_en_i    (pop_w),
        .rd_data_o  (stage_w),
        .full_o     (fifo_full_w),
        .empty_o    (fifo_empty_w),
        .count_o    (fifo_count_w)
    );

    assign stage_ts_w = cmd_ts(stage_w);

    // A full FIFO still takes a write when the same edge pops the head.
    assign push_w    = bus.wr_valid & ~bus.flush & (~fifo_full_w | pop_w);
    assign ovf_set_w = bus.wr_valid & ~bus.flush & fifo_full_w & ~pop_w;

    always_comb begin
        state_d    = state_q;
        pop_w      = 1'b0;
        fire_w     = 1'b0;
        late_set_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (avail_q && !fifo_empty_w && bus.enable) begin
                    pop_w   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.enable && (bus.timeline >= stage_ts_w)) begin
                    if (bus.busy) begin
                        state_d = ST_STALL;
                    end else begin
                        fire_w     = 1'b1;
                        late_set_w = (bus.timeline != stage_ts_w);
                        state_d    = ST_FIRE;
                    end
                end
            end
            ST_STALL: begin
                if (!bus.busy) begin
                    fire_w     = 1'b1;
                    late_set_w = 1'b1;
                    state_d    = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (!fifo_empty_w && bus.enable) begin
                    pop_w   = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_d    = ST_IDLE;
            pop_w      = 1'b0;
            fire_w     = 1'b0;
            late_set_w = 1'b0;
        end
    end

    // avail_q lets a freshly written head settle one cycle before IDLE pops it.
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            avail_q    <= 1'b0;
            matched_q  <= 1'b0;
            gpo_data_q <= '0;
            ovf_q      <= 1'b0;
            late_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            avail_q   <= ~bus.flush & ~fifo_empty_w;
            matched_q <= fire_w;
            if (fire_w) begin
                gpo_data_q <= stage_w;
            end
            ovf_q  <= ovf_set_w  | (ovf_q  & ~bus.err_clear);
            late_q <= late_set_w | (late_q & ~bus.err_clear);
        end
    end

    assign bus.wr_ready        = ~fifo_full_w;
    assign bus.counter_matched = matched_q;
    assign bus.gpo_data        = gpo_data_q;
    assign bus.fifo_count      = fifo_count_w;
    assign bus.overflow_error  = ovf_q;
    assign bus.late_error      = late_q;

endmodule
`default_nettype wire

// File: doc/gpo_event_scheduler.md
Name: gpo_event_scheduler

Overview:
- Timed-event sequencer that sits in front of one GPO core in a DAC controller.
- Buffers timestamped 128-bit GPO commands written by the AXI distribution logic and compares the head entry against the free-running 64-bit timeline counter.
- At the matching cycle, presents the entry and pulses counter_matched into the GPO core.
- Never pulses while the core reports busy; instead it defers the event and flags the lateness, so the core's busy_error path is never triggered by this block.

Parameters:
- FIFO_DEPTH_LOG2, 4, log2 of command FIFO depth (depth 16).
- TS_WIDTH, 64, timestamp/counter width; occupies wr_data[127:64].

Ports:
- CLK100MHZ  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  1 = scheduling runs; 0 = head entry is held and no pulse is issued.
- flush  in  1  synchronous clear of FIFO and staging; takes priority over everything except resetn.
- wr_valid  in  1  write request.
- wr_data  in  128  [127:64] timestamp, [63:0] GPO value.
- wr_ready  out  1  equals ~fifo_full.
- timeline  in  64  global time counter.
- busy  in  1  downstream GPO busy.
- counter_matched  out  1  one-cycle fire pulse to GPO core.
- gpo_data  out  128  command presented with the pulse: {timestamp, value}.
- fifo_count  out  FIFO_DEPTH_LOG2+1  entries stored, excluding the staged entry.
- overflow_error  out  1  sticky; a write was attempted while full.
- late_error  out  1  sticky; an event fired after its timestamp.
- err_clear  in  1  clears both sticky errors.

Behaviour:
- Reset (resetn=0, asynchronous):
  - FIFO empty, state IDLE.
  - counter_matched=0, gpo_data=0, fifo_count=0.
  - overflow_error=0, late_error=0, wr_ready=1.
- Write:
  - Accepted when wr_valid & wr_ready.
  - A write while full is dropped and sets overflow_error.
  - A simultaneous write and pop is legal when the FIFO is full; count is unchanged.
- State machine:
  - IDLE: if FIFO non-empty and enable=1, pop head into the staging register, go to WAIT. Write-to-empty reaches WAIT 2 cycles after the accepting edge.
  - WAIT, enable=0: hold.
  - WAIT, timeline == ts and busy=0: go to FIRE.
  - WAIT, timeline > ts (unsigned) and busy=0: go to FIRE and set late_error.
  - WAIT, (timeline >= ts) and busy=1: go to STALL.
  - STALL: when busy=0 go to FIRE and set late_error; while busy=1 hold with counter_matched=0.
  - FIRE:
    - counter_matched=1 for exactly this cycle; gpo_data = staged entry, stable during the pulse.
    - If FIFO non-empty and enable=1, pop the next entry directly and go to WAIT (back-to-back events 2 cycles apart minimum); else go to IDLE.
- Outputs from registers:
  - counter_matched is a registered output.
  - gpo_data holds its last value after the pulse; it updates only on FIRE entry.
- Timestamp compare:
  - Full 64-bit unsigned; no wrap handling (the 64-bit counter is assumed never to wrap in operation).
  - Equal timestamps in consecutive entries: the second fires 2 cycles later and is marked late.
- flush:
  - Empties the FIFO, discards the staged entry, returns to IDLE, forces counter_matched=0 next cycle.
  - Does not clear the sticky errors.
  - A write in the same cycle as flush is discarded.
- err_clear coincident with a new error event: the set wins.
- enable deassert mid-WAIT: the entry is retained; it resumes when enable returns, and is late if time has passed.

Decomposition:
- Package gpo_sched_pkg:
  - state enum {IDLE, WAIT, STALL, FIRE}.
  - TS_WIDTH, GPO_CMD_WIDTH=128.
  - Field-slice localparams (TS_MSB=127, TS_LSB=64).
- Sub-module gpo_sched_fifo: synchronous single-clock FIFO with full/empty/count and first-word-not-fallthrough pop. The scheduler FSM stays in the top module.

Test Plan:
- Reset, then write {ts=100, val=0xA5}, timeline ramps from 0 → exactly one counter_matched pulse at the cycle after timeline==100; gpo_data=0x…0064_…00A5; late_error=0.
- Write 17 entries with the FIFO held (enable=0) → wr_ready=0 after 16; 17th dropped; overflow_error=1; fifo_count=16; err_clear → 0.
- Entry ts=50, busy=1 over timeline 48..60 → no pulse while busy; pulse the cycle after busy falls; late_error=1.
- Write ts=10 when timeline=200 → fires 3 cycles after the write; late_error=1.
- Entries ts=300 and ts=300 → pulses at 301 and 303, the second flagged late; 3 entries then flush at timeline 250 → no pulses; fifo_count=0; state IDLE.
- Assert resetn=0 during STALL → counter_matched, gpo_data and errors are 0 immediately (asynchronous); no pulse after release.
